// File: rtl/disp_conf_writer.sv
// Packs zero-extended {disp, conf} words into wide beats and writes one frame over Avalon-MM.
// Optional stall statistics are built when DISP_CONF_WRITER_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for frame_start
// FILL  | accepting input words into lanes
// WRITE | presenting one beat to the memory interface
// DONE  | one-cycle frame_done pulse
module disp_conf_writer #(
  parameter int          disp_bits      = 5,
  parameter int          frame_width    = 320,
  parameter int          frame_height   = 240,
  parameter int          words_per_beat = 4,
  parameter logic [31:0] base_addr      = 32'h0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_start,
  input  logic [disp_bits+7:0]        disp_conf_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [31:0]                 avm_address,
  output logic                        avm_write,
  output logic [16*words_per_beat-1:0] avm_writedata,
  input  logic                        avm_waitrequest,
  output logic                        frame_done,
  output logic                        busy,
  output logic [31:0]                 stall_cycles
);

  localparam int          data_w    = 16 * words_per_beat;
  localparam int          num_beats = frame_width * frame_height / words_per_beat;
  localparam int          lane_w    = $clog2(words_per_beat);
  localparam int          beat_w    = $clog2(num_beats + 1);
  localparam logic [31:0] addr_step = 32'(2 * words_per_beat);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [lane_w-1:0]   lane_cnt;
  logic [beat_w-1:0]   beat_cnt;
  logic [31:0]         addr_q;
  logic [data_w-1:0]   data_q;
  logic                xfer, beat_ack, last_lane, last_beat, start_ok;

  assign start_ok  = (state == IDLE) && frame_start;
  assign xfer      = (state == FILL) && in_valid;
  assign beat_ack  = (state == WRITE) && !avm_waitrequest;
  assign last_lane = (lane_cnt == lane_w'(words_per_beat - 1));
  assign last_beat = (beat_cnt == beat_w'(num_beats - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = FILL;
      FILL:    if (xfer && last_lane) state_next = WRITE;
      WRITE:   if (!avm_waitrequest) state_next = last_beat ? DONE : FILL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane counter wraps naturally because words_per_beat is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt <= '0;
      beat_cnt <= '0;
      addr_q   <= base_addr;
      data_q   <= '0;
    end else begin
      if (start_ok) begin
        addr_q   <= base_addr;
        lane_cnt <= '0;
        beat_cnt <= '0;
      end
      if (xfer) begin
        data_q[int'(lane_cnt)*16 +: 16] <= 16'(disp_conf_in);
        lane_cnt <= lane_cnt + lane_w'(1);
      end
      if (beat_ack) begin
        addr_q   <= addr_q + addr_step;
        beat_cnt <= beat_cnt + beat_w'(1);
      end
    end
  end

  assign in_ready      = (state == FILL);
  assign avm_write     = (state == WRITE);
  assign frame_done    = (state == DONE);
  assign busy          = (state != IDLE);
  assign avm_address   = addr_q;
  assign avm_writedata = data_q;

`ifdef DISP_CONF_WRITER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   stall_q <= '0;
    else if (start_ok)                              stall_q <= '0;
    else if (avm_write && avm_waitrequest && stall_q != 32'hFFFF_FFFF)
                                                    stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_disp_conf_writer.sv
// Directed bench for disp_conf_writer: a word-list model predicts every beat and its timing.
module tb_disp_conf_writer;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        frame_start = 0;
  logic [12:0] disp_conf_in = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic        avm_waitrequest = 0;
  logic        frame_done;
  logic        busy;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_left = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [31:0] acc_addr[$];
  logic [63:0] acc_data[$];

  bit          prev_write, prev_wait, done_exp, ready_exp, write_exp;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  int          xfer_cnt, beats_seen, write_cycles;

  disp_conf_writer #(
    .disp_bits(5), .frame_width(4), .frame_height(2),
    .words_per_beat(4), .base_addr(32'h1000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .disp_conf_in(disp_conf_in), .in_valid(in_valid), .in_ready(in_ready),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .frame_done(frame_done), .busy(busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Slave stall generator: holds waitrequest for stall_left write cycles.
  always @(posedge clk) begin
    #1;
    if (avm_write && stall_left > 0) begin
      avm_waitrequest = 1;
      stall_left--;
    end else begin
      avm_waitrequest = 0;
    end
  end

  // Compare process: beat contents, hold stability and cycle-level timing.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_write = 0; prev_wait = 0; done_exp = 0; ready_exp = 0; write_exp = 0;
      xfer_cnt = 0; beats_seen = 0;
    end else begin
      check("frame_done_timing", frame_done, done_exp);
      if (ready_exp) check("ready_after_beat", in_ready, 1);
      if (write_exp) check("write_after_last_lane", avm_write, 1);
      if (prev_write && prev_wait) begin
        check("hold_write", avm_write, 1);
        check("hold_addr", avm_address, prev_addr);
        check("hold_data", avm_writedata, prev_data);
      end
      if (avm_write) begin
        write_cycles++;
        check("ready_low_in_write", in_ready, 0);
      end
      done_exp = 0; ready_exp = 0; write_exp = 0;
      if (in_valid && in_ready) begin
        xfer_cnt++;
        if (xfer_cnt == 4) begin xfer_cnt = 0; write_exp = 1; end
      end
      if (avm_write && !avm_waitrequest) begin
        acc_addr.push_back(avm_address);
        acc_data.push_back(avm_writedata);
        if (exp_addr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          check("beat_addr", avm_address, exp_addr.pop_front());
          check("beat_data", avm_writedata, exp_data.pop_front());
        end
        beats_seen++;
        if (beats_seen == 2) begin done_exp = 1; beats_seen = 0; end
        else ready_exp = 1;
      end
      prev_write = avm_write; prev_wait = avm_waitrequest;
      prev_addr = avm_address; prev_data = avm_writedata;
    end
  end

  task automatic summary_and_fatal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "bench aborted");
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic send_word(input logic [12:0] w, input bit pulse_start);
    bit got;
    int n = 0;
    in_valid = 1;
    disp_conf_in = w;
    if (pulse_start) frame_start = 1;
    forever begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      frame_start = 0;
      if (got) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 0, 1);
        summary_and_fatal();
      end
    end
  endtask

  task automatic pulse_frame_start();
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
  endtask

  function automatic logic [12:0] word_of(input int pat, input int i);
    if (pat == 0) return 13'(i + 1);
    return {5'(i * 3 + 17), 8'(8'hA5 ^ 8'(i * 17))};
  endfunction

  task automatic run_frame(input int pat, input bit bubble, input int stall, input bit mid_start);
    logic [12:0] w;
    logic [63:0] d = '0;
    int beat = 0;
    int n = 0;
    stall_left = stall;
    pulse_frame_start();
    for (int i = 0; i < 8; i++) begin
      w = word_of(pat, i);
      d[(i % 4) * 16 +: 16] = 16'(w);
      if (i % 4 == 3) begin
        exp_addr.push_back(32'h1000 + 32'(8 * beat));
        exp_data.push_back(d);
        beat++;
      end
      send_word(w, mid_start && i == 2);
      if (bubble) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
    end
    in_valid = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 100);
    check("frame_done_seen", frame_done, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);
    check("queue_drained", exp_addr.size(), 0);
  endtask

  initial begin
    int wc0;
    logic [31:0] exp_stall;
`ifdef DISP_CONF_WRITER_STATS_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    // Reset with input activity
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 in_valid = (i % 2 == 0); disp_conf_in = 13'h1ABC;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
    end
    in_valid = 0;
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 32'h1000);
    check("rst_data", avm_writedata, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_cycles, 0);
    @(negedge clk) reset_n = 1;

    // Basic frame
    acc_addr.delete(); acc_data.delete();
    run_frame(0, 0, 0, 0);
    check("basic_nbeats", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("basic_addr0", acc_addr[0], 32'h1000);
      check("basic_data0", acc_data[0], 64'h0004_0003_0002_0001);
      check("basic_addr1", acc_addr[1], 32'h1008);
      check("basic_data1", acc_data[1], 64'h0008_0007_0006_0005);
    end

    // Backpressure: 3 stalled cycles on beat 0
    wc0 = write_cycles;
    run_frame(1, 0, 3, 0);
    check("bp_write_cycles", write_cycles - wc0, 5);
    check("bp_stall_cycles", stall_cycles, exp_stall);

    // Bubbled input gives the same beats as the basic frame
    acc_addr.delete(); acc_data.delete();
    run_frame(0, 1, 0, 0);
    check("bub_nbeats", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("bub_addr0", acc_addr[0], 32'h1000);
      check("bub_data0", acc_data[0], 64'h0004_0003_0002_0001);
      check("bub_addr1", acc_addr[1], 32'h1008);
      check("bub_data1", acc_data[1], 64'h0008_0007_0006_0005);
    end

    // frame_start mid-FILL is ignored; stats cleared by this frame's start
    acc_addr.delete(); acc_data.delete();
    run_frame(1, 0, 0, 1);
    check("rearm_nbeats", acc_addr.size(), 2);
    check("rearm_stall_clear", stall_cycles, 0);

    // Reset while a write is held
    stall_left = 100;
    pulse_frame_start();
    for (int i = 0; i < 4; i++) send_word(word_of(0, i), 0);
    in_valid = 0;
    check("mid_write_before", avm_write, 1);
    #2 reset_n = 0;
    #1;
    check("mid_write_dropped", avm_write, 0);
    check("mid_write_busy", busy, 0);
    stall_left = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    exp_addr.delete(); exp_data.delete();
    wc0 = write_cycles;
    repeat (20) @(negedge clk);
    check("no_write_after_reset", write_cycles - wc0, 0);

    // Fresh frame after reset starts at base
    acc_addr.delete(); acc_data.delete();
    run_frame(0, 0, 0, 0);
    check("post_rst_nbeats", acc_addr.size(), 2);
    if (acc_addr.size() == 2) check("post_rst_addr0", acc_addr[0], 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
